// File: rtl/ldpc_asm_randomizer.sv
// ldpc_asm_randomizer: frames LDPC codeblocks into CADUs (ASM + randomized codeblock bits) on a serial AXI-Stream link
module ldpc_asm_randomizer #(
  parameter int          CB_LEN  = 8176,
  parameter logic [31:0] ASM     = 32'h1ACFFC1D,
  parameter bit          RAND_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic s_axis_tlast,
  output logic m_axis_tdata,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  input  logic m_axis_tready,
  output logic len_err
);
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
  state_t state, state_nx;
  logic [4:0] asm_cnt;
  logic [12:0] bit_cnt;
  logic [7:0] lfsr;
  logic free, hs, cnt_last, cb_end;
  assign free = !m_axis_tvalid || m_axis_tready;
  assign hs = s_axis_tvalid && s_axis_tready;
  assign cnt_last = bit_cnt == 13'(CB_LEN - 1);
  assign cb_end = s_axis_tlast || cnt_last;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: wake on offered data, leave SYNC after the 32nd ASM bit, close the CADU on tlast or full length
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = s_axis_tvalid ? SYNC : IDLE;
      SYNC:    state_nx = (free && asm_cnt == 5'd31) ? DATA : SYNC;
      DATA:    state_nx = (hs && cb_end) ? IDLE : DATA;
      default: state_nx = IDLE;
    endcase
  end
  // input is only accepted while streaming codeblock bits into a free slot
  always_comb s_axis_tready = (state == DATA) && free;
  // slot, counters and randomizer move only when the slot can take a new bit; a stall freezes everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_axis_tdata  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      asm_cnt       <= 5'd0;
      bit_cnt       <= 13'd0;
      lfsr          <= 8'hFF;
    end else if (free) begin
      m_axis_tvalid <= (state == SYNC) || hs;
      m_axis_tdata  <= (state == SYNC) ? ASM[5'd31 - asm_cnt] :
                       hs ? (s_axis_tdata ^ (RAND_EN & lfsr[0])) : m_axis_tdata;
      m_axis_tlast  <= hs && cb_end;
      asm_cnt       <= (state == SYNC) ? asm_cnt + 5'd1 : 5'd0;
      bit_cnt       <= (state != DATA) ? 13'd0 : hs ? (cb_end ? 13'd0 : bit_cnt + 13'd1) : bit_cnt;
      lfsr          <= (state != DATA) ? 8'hFF : hs ? {lfsr[7] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0], lfsr[7:1]} : lfsr;
    end
  // length error is a single-cycle pulse aligned with the offending tlast bit entering the slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) len_err <= 1'b0;
    else len_err <= hs && (s_axis_tlast != cnt_last);
endmodule

// File: tb/tb_ldpc_asm_randomizer.sv
// tb_ldpc_asm_randomizer: vector table plus scoreboard checking CADU framing, randomization and length errors
module tb_ldpc_asm_randomizer;
  localparam int CB = 8176;
  typedef struct { bit d; bit l; bit e; } exp_t;
  typedef struct { int n; int tl; int pat; bit sel; bit rnd; bit drain; int err; int lasts; int last_idx; bit chk_cap; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_tdata = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic sel = 1'b0;
  bit rnd = 1'b0;
  logic s_tready0, m_tdata0, m_tvalid0, m_tlast0, len_err0;
  logic s_tready1, m_tdata1, m_tvalid1, m_tlast1, len_err1;
  logic s_tready, m_tdata, m_tvalid, m_tlast, len_err;
  exp_t q[$];
  bit pn_seq[CB];
  logic [31:0] asm_v = 32'h1ACFFC1D;
  logic [63:0] cap = '0;
  int errors = 0, checks = 0, mcnt = 0, n_errp = 0, n_last = 0, last_idx = -1, obs_idx = 0;

  assign s_tready = sel ? s_tready1 : s_tready0;
  assign m_tdata  = sel ? m_tdata1  : m_tdata0;
  assign m_tvalid = sel ? m_tvalid1 : m_tvalid0;
  assign m_tlast  = sel ? m_tlast1  : m_tlast0;
  assign len_err  = sel ? len_err1  : len_err0;

  always #5 clk = ~clk;

  ldpc_asm_randomizer #(.RAND_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid & !sel), .s_axis_tready(s_tready0), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tlast(m_tlast0),
    .m_axis_tready(m_tready), .len_err(len_err0));
  ldpc_asm_randomizer #(.RAND_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid & sel), .s_axis_tready(s_tready1), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tlast(m_tlast1),
    .m_axis_tready(m_tready), .len_err(len_err1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // push the expected CADU bits for this input bit, then hold it on the bus until accepted
  task automatic send_bit(input bit d, input bit tl);
    bit lst;
    int waited;
    if (rnd && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    if (mcnt == 0) for (int i = 31; i >= 0; i--) q.push_back('{asm_v[i], 1'b0, 1'b0});
    lst = tl || (mcnt == CB - 1);
    q.push_back('{d ^ (!sel & pn_seq[mcnt]), lst, tl != (mcnt == CB - 1)});
    mcnt = lst ? 0 : mcnt + 1;
    s_tdata = d; s_tlast = tl; s_tvalid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      if (++waited > 1000) begin
        $display("FAIL input_accept: s_axis_tready stuck 0, expected 1");
        $fatal(1, "input never accepted");
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic bit pat_bit(input int p, input int i);
    return p == 0 ? 1'b0 : p == 1 ? (i % 2 == 0) : 1'($urandom_range(0, 1));
  endfunction

  initial forever begin
    @(posedge clk); #1;
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor: scoreboard pop, stall stability, len_err alignment
  initial begin
    bit pv, px, pd, pl;
    exp_t x;
    pv = 0; px = 0; pd = 0; pl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; px = 0; obs_idx = 0;
      end else begin
        if (pv && !px) chk("stall_hold", {m_tvalid, m_tdata, m_tlast}, {1'b1, pd, pl});
        if (len_err) n_errp++;
        if (m_tvalid && (!pv || px) && q.size() != 0) chk("len_err", len_err, q[0].e);
        if (m_tvalid && m_tready) begin
          if (q.size() == 0) chk("unexpected_bit", 1, 0);
          else begin
            x = q.pop_front();
            chk("data", m_tdata, x.d);
            chk("last", m_tlast, x.l);
            if (obs_idx < 64) cap = {cap[62:0], m_tdata};
            if (m_tlast) begin n_last++; last_idx = obs_idx; obs_idx = 0; end
            else obs_idx++;
          end
        end
        pv = m_tvalid; px = m_tvalid && m_tready; pd = m_tdata; pl = m_tlast;
      end
    end
  end

  initial begin
    vec_t v[8];
    bit a[CB + 8];
    int e0, l0;
    for (int i = 0; i < 8; i++) a[i] = 1'b1;
    for (int i = 0; i < CB; i++) a[i + 8] = a[i + 7] ^ a[i + 5] ^ a[i + 3] ^ a[i];
    for (int i = 0; i < CB; i++) pn_seq[i] = a[i];
    v[0] = '{8176, 8175, 0, 1'b0, 1'b0, 1'b1, 0, 1, 8207, 1'b1};
    v[1] = '{8176, 8175, 1, 1'b1, 1'b0, 1'b1, 0, 1, 8207, 1'b0};
    v[2] = '{8176, 8175, 2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0};
    v[3] = '{300, 299, 2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0};
    v[4] = '{500, 499, 2, 1'b0, 1'b1, 1'b1, 2, 3, 531, 1'b0};
    v[5] = '{101, 100, 0, 1'b0, 1'b0, 1'b1, 1, 1, 132, 1'b1};
    v[6] = '{200, 199, 0, 1'b0, 1'b0, 1'b1, 1, 1, 231, 1'b1};
    v[7] = '{8200, -1, 0, 1'b0, 1'b0, 1'b1, 1, 1, 8207, 1'b0};
    #12;
    chk("rst_tdata", m_tdata0, 0);
    chk("rst_tvalid", m_tvalid0, 0);
    chk("rst_tlast", m_tlast0, 0);
    chk("rst_len_err", len_err0, 0);
    chk("rst_tready", s_tready0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e0 = 0; l0 = 0;
    for (int k = 0; k < 8; k++) begin
      sel = v[k].sel; rnd = v[k].rnd;
      for (int i = 0; i < v[k].n; i++) send_bit(pat_bit(v[k].pat, i), i == v[k].tl);
      if (v[k].drain) begin
        rnd = 1'b0;
        drain();
        chk("len_err_count", n_errp - e0, v[k].err);
        chk("tlast_count", n_last - l0, v[k].lasts);
        chk("tlast_index", last_idx, v[k].last_idx);
        if (v[k].chk_cap) chk("cadu_head", cap, 64'h1ACFFC1D_FF480EC0);
        e0 = n_errp; l0 = n_last;
      end
    end
    // reset mid-codeblock abandons the frame; next frame starts with a fresh ASM and LFSR
    sel = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    q.delete(); mcnt = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tdata", m_tdata, 0);
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_len_err", len_err, 0);
    chk("midrst_tready", s_tready, 0);
    q.delete(); mcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = n_errp; l0 = n_last;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) send_bit(1'b0, i == 63);
    drain();
    chk("post_rst_head", cap, 64'h1ACFFC1D_FF480EC0);
    chk("post_rst_tlast_index", last_idx, 95);
    chk("post_rst_len_err_count", n_errp - e0, 1);
    chk("post_rst_tlast_count", n_last - l0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
